// File: rtl/l2_mem_responder_pkg.sv
// Shared definitions for the L2<->MEM line interface: widths, the responder
// state encoding and the {tag, index} line-address helper.
package mem_if_pkg;

  localparam int LINE_W      = 512;
  localparam int TAG_W       = 18;
  localparam int INDEX_W     = 8;
  localparam int LINE_ADDR_W = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Full line address as seen by the L2; the responder keeps only its low bits.
  function automatic logic [LINE_ADDR_W-1:0] line_addr(
    input logic [TAG_W-1:0]   tag,
    input logic [INDEX_W-1:0] index
  );
    return {tag, index};
  endfunction

endpackage

// File: rtl/l2_mem_responder_if.sv
// L2<->MEM line bus. The L2 (master) drives level requests plus address/data;
// the memory (slave) returns a fill line and a one-cycle ready pulse.
interface l2_mem_responder_if;
  import mem_if_pkg::*;

  logic                 read_L2_MEM;
  logic                 write_L2_MEM;
  logic [INDEX_W-1:0]   index_L2_MEM;
  logic [TAG_W-1:0]     tag_L2_MEM;
  logic [TAG_W-1:0]     write_tag_L2_MEM;
  logic [LINE_W-1:0]    write_data_L2_MEM;
  logic [LINE_W-1:0]    read_data_MEM_L2;
  logic                 ready_MEM_L2;

  modport master (
    output read_L2_MEM, write_L2_MEM, index_L2_MEM, tag_L2_MEM,
           write_tag_L2_MEM, write_data_L2_MEM,
    input  read_data_MEM_L2, ready_MEM_L2
  );

  modport slave (
    input  read_L2_MEM, write_L2_MEM, index_L2_MEM, tag_L2_MEM,
           write_tag_L2_MEM, write_data_L2_MEM,
    output read_data_MEM_L2, ready_MEM_L2
  );

endinterface

// File: rtl/l2_mem_responder_store.sv
// Line-granular backing store: one write port, one registered read port,
// no reset so it maps onto block RAM. The read register holds its value
// until the next read enable.
module mem_line_store
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [LINE_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem [2**ADDR_W];
  logic [LINE_W-1:0] rdata_q;

  // Synchronous write and registered read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/l2_mem_responder.sv
// Main-memory responder for L2 fills and writebacks with counter-modelled
// latency. A combined request performs the write first, then the read, and
// returns a single ready pulse. Optional macro MEM_STATS_EN adds read/write
// completion counters (rd_count_o, wr_count_o).
module l2_mem_responder
  import mem_if_pkg::*;
#(
  parameter int READ_LAT   = 8,
  parameter int WRITE_LAT  = 4,
  parameter int MEM_ADDR_W = 10
) (
  input  logic                clk,
  input  logic                nrst,
  l2_mem_responder_if.slave   bus
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]         rd_count_o,
  output logic [31:0]         wr_count_o
`endif
);

  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LAT - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [MEM_ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [MEM_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [LINE_W-1:0]       wr_data_q, wr_data_d;
  logic                    rd_pend_q, rd_pend_d;
  logic                    ready_q, ready_d;
  // Set once the store read register holds a real fill; until then the
  // output reads as zero, since the store itself is never reset.
  logic                    loaded_q, loaded_d;
  logic                    store_we, store_re;
  logic [LINE_W-1:0]       store_rdata;

  // Next-state, capture and store strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_pend_d = rd_pend_q;
    loaded_d  = loaded_q;
    ready_d   = 1'b0;
    store_we  = 1'b0;
    store_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.write_L2_MEM) begin
          wr_addr_d = MEM_ADDR_W'(line_addr(bus.write_tag_L2_MEM, bus.index_L2_MEM));
          wr_data_d = bus.write_data_L2_MEM;
          rd_pend_d = bus.read_L2_MEM;
          if (bus.read_L2_MEM)
            rd_addr_d = MEM_ADDR_W'(line_addr(bus.tag_L2_MEM, bus.index_L2_MEM));
          cnt_d   = WR_LOAD;
          state_d = WR_WAIT;
        end else if (bus.read_L2_MEM) begin
          rd_addr_d = MEM_ADDR_W'(line_addr(bus.tag_L2_MEM, bus.index_L2_MEM));
          cnt_d     = RD_LOAD;
          state_d   = RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          store_we = 1'b1;
          if (rd_pend_q) begin
            rd_pend_d = 1'b0;
            cnt_d     = RD_LOAD;
            state_d   = RD_WAIT;
          end else begin
            ready_d = 1'b1;
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          store_re = 1'b1;
          loaded_d = 1'b1;
          ready_d  = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        // Requests are still high this cycle; ignore them.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and captured-request registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_pend_q <= 1'b0;
      ready_q   <= 1'b0;
      loaded_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_pend_q <= rd_pend_d;
      ready_q   <= ready_d;
      loaded_q  <= loaded_d;
    end
  end

  mem_line_store #(
    .ADDR_W (MEM_ADDR_W)
  ) u_store (
    .clk   (clk),
    .we    (store_we),
    .waddr (wr_addr_q),
    .wdata (wr_data_q),
    .re    (store_re),
    .raddr (rd_addr_q),
    .rdata (store_rdata)
  );

  assign bus.ready_MEM_L2     = ready_q;
  assign bus.read_data_MEM_L2 = loaded_q ? store_rdata : '0;

`ifdef MEM_STATS_EN
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] wr_count_q, wr_count_d;

  // Completion counters step on read data load and on write commit.
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (store_re) rd_count_d = rd_count_q + 32'd1;
    if (store_we) wr_count_d = wr_count_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count_o = rd_count_q;
  assign wr_count_o = wr_count_q;
`endif

endmodule

// File: tb/tb_l2_mem_responder.sv
// Self-checking bench for l2_mem_responder: directed cases plus randomized
// transactions checked against a line-array reference model.
module tb_l2_mem_responder;
  import mem_if_pkg::*;

  localparam int RL = 8;
  localparam int WL = 4;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  l2_mem_responder_if bus();

`ifdef MEM_STATS_EN
  logic [31:0] rd_count_o, wr_count_o;
  int          exp_rd_n = 0, exp_wr_n = 0;
`endif

  l2_mem_responder #(
    .READ_LAT   (RL),
    .WRITE_LAT  (WL),
    .MEM_ADDR_W (AW)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
`ifdef MEM_STATS_EN
    ,
    .rd_count_o (rd_count_o),
    .wr_count_o (wr_count_o)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [511:0] model_mem [1024];
  logic [511:0] last_read = '0;

  typedef struct packed {
    logic [17:0] tag;
    logic [7:0]  idx;
  } addr_t;
  addr_t pool [8];

  task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] maddr(input logic [17:0] tag, input logic [7:0] idx);
    logic [25:0] full;
    full = {tag, idx};
    return full[9:0];
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic drive_idle();
    bus.read_L2_MEM       = 1'b0;
    bus.write_L2_MEM      = 1'b0;
    bus.index_L2_MEM      = '0;
    bus.tag_L2_MEM        = '0;
    bus.write_tag_L2_MEM  = '0;
    bus.write_data_L2_MEM = '0;
  endtask

  // One full transaction: called at posedge+1; returns at posedge+1 with the
  // requests dropped after the DONE cycle. perturb scrambles the inputs in
  // cycle 2 (after acceptance).
  task automatic txn(input bit rd, input bit wr, input logic [17:0] tag,
                     input logic [17:0] wtag, input logic [7:0] idx,
                     input logic [511:0] wd, input bit perturb);
    int got_lat;
    int exp_lat;
    bus.read_L2_MEM       = rd;
    bus.write_L2_MEM      = wr;
    bus.tag_L2_MEM        = tag;
    bus.write_tag_L2_MEM  = wtag;
    bus.index_L2_MEM      = idx;
    bus.write_data_L2_MEM = wd;
    @(posedge clk);  // accepting edge
    if (wr) model_mem[maddr(wtag, idx)] = wd;
    if (rd) last_read = model_mem[maddr(tag, idx)];
    exp_lat = (rd && wr) ? WL + RL : (wr ? WL : RL);
`ifdef MEM_STATS_EN
    if (rd) exp_rd_n++;
    if (wr) exp_wr_n++;
`endif
    got_lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (perturb && c == 2) begin
        bus.index_L2_MEM      = 8'hFF;
        bus.write_data_L2_MEM = rand_line();
        bus.write_tag_L2_MEM  = 18'h3FFFF;
        bus.tag_L2_MEM        = 18'h3FFFF;
      end
      if (bus.ready_MEM_L2 === 1'b1) begin
        got_lat = c;
        break;
      end
    end
    check_val("latency", 512'(got_lat), 512'(exp_lat));
    check_val("read_data", bus.read_data_MEM_L2, last_read);
    @(posedge clk); #1;
    check_val("done_ready_low", 512'(bus.ready_MEM_L2), 512'd0);
    drive_idle();
    $display("txn rd=%0d wr=%0d tag=%05h wtag=%05h idx=%02h lat=%0d exp_lat=%0d",
             rd, wr, tag, wtag, idx, got_lat, exp_lat);
  endtask

  logic [511:0] a5_line;
  logic [511:0] ff_line;
  logic [511:0] line_05;

  initial begin
    drive_idle();
    a5_line = {64{8'hA5}};
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;

    // Reset and idle.
    repeat (3) @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check_val("idle_ready", 512'(bus.ready_MEM_L2), 512'd0);
    end
    check_val("idle_read_data", bus.read_data_MEM_L2, 512'd0);
    $display("txn reset+idle 20 cycles");
`ifdef MEM_STATS_EN
    check_val("rd_count_reset", 512'(rd_count_o), 512'd0);
    check_val("wr_count_reset", 512'(wr_count_o), 512'd0);
`endif

    // Write then read at tag 1 / index 05.
    txn(1'b0, 1'b1, 18'h0, 18'h00001, 8'h05, a5_line, 1'b0);
    txn(1'b1, 1'b0, 18'h00001, 18'h0, 8'h05, '0, 1'b0);

    // Combined read+write, aliasing address.
    txn(1'b1, 1'b1, 18'h2, 18'h2, 8'h10, 512'h1, 1'b0);

    // Read in flight, reset pulsed in cycle 3.
    bus.read_L2_MEM  = 1'b1;
    bus.tag_L2_MEM   = 18'h00001;
    bus.index_L2_MEM = 8'h05;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 nrst = 1'b0;
    drive_idle();
    last_read = '0;
`ifdef MEM_STATS_EN
    exp_rd_n = 0;
    exp_wr_n = 0;
`endif
    #1;
    check_val("rst_ready", 512'(bus.ready_MEM_L2), 512'd0);
    check_val("rst_read_data", bus.read_data_MEM_L2, 512'd0);
    @(negedge clk) nrst = 1'b1;
    for (int i = 0; i < RL + 2; i++) begin
      @(posedge clk); #1;
      check_val("post_rst_no_ready", 512'(bus.ready_MEM_L2), 512'd0);
    end
    $display("txn reset mid-read");
    txn(1'b1, 1'b0, 18'h00001, 18'h0, 8'h05, '0, 1'b0);

    // Write with inputs changed mid-flight: index FF must stay intact.
    ff_line = rand_line();
    txn(1'b0, 1'b1, 18'h0, 18'h00001, 8'hFF, ff_line, 1'b0);
    line_05 = rand_line();
    txn(1'b0, 1'b1, 18'h0, 18'h00001, 8'h05, line_05, 1'b1);
    txn(1'b1, 1'b0, 18'h00001, 18'h0, 8'h05, '0, 1'b0);
    check_val("perturb_committed", bus.read_data_MEM_L2, line_05);
    txn(1'b1, 1'b0, 18'h00001, 18'h0, 8'hFF, '0, 1'b0);
    check_val("perturb_ff_kept", bus.read_data_MEM_L2, ff_line);

    // Address wrap: tag bits above the store depth are dropped.
    txn(1'b0, 1'b1, 18'h0, 18'h00004, 8'h33, rand_line(), 1'b0);
    txn(1'b1, 1'b0, 18'h00000, 18'h0, 8'h33, '0, 1'b0);

    // Randomized traffic over a small pool, pre-written so reads are defined.
    for (int i = 0; i < 8; i++) begin
      pool[i].tag = 18'($urandom_range(0, 7));
      pool[i].idx = 8'($urandom());
      txn(1'b0, 1'b1, 18'h0, pool[i].tag, pool[i].idx, rand_line(), 1'b0);
    end
    for (int i = 0; i < 30; i++) begin
      int  k;
      int  kw;
      int  kind;
      bit  rd;
      bit  wr;
      k    = $urandom_range(0, 7);
      kw   = $urandom_range(0, 7);
      kind = $urandom_range(0, 2);
      rd   = (kind != 1);
      wr   = (kind != 0);
      // Shared index: write victim uses pool[kw].tag but the read index.
      if (wr) pool[kw].idx = pool[k].idx;
      txn(rd, wr, pool[k].tag, pool[kw].tag, pool[k].idx, rand_line(), 1'b0);
    end

`ifdef MEM_STATS_EN
    check_val("rd_count", 512'(rd_count_o), 512'(exp_rd_n));
    check_val("wr_count", 512'(wr_count_o), 512'(exp_wr_n));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
